pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Merges four hazard sources into one set of per-stage write-enable and flush controls plus PCSel:
  - EX-stage control transfer (branch taken, JAL, JALR)
  - ID load-use dependency
  - multi-cycle MUL/DIV occupancy of EX
  - data-memory wait on the MEM stage
- Replaces ad-hoc stall logic; sits beside the stage registers and drives them directly.

---
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/PCSel sequencer for the 5-stage RV32 pipeline
// Define HAZ_PERF_CNT_EN to build the stall_cnt/flush_cnt performance counters.
`ifndef JAL
`define JAL 7'b1101111
`endif
`ifndef JALR
`define JALR 7'b1100111
`endif

module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_MAX_CYC = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic [6:0]       ex_opcode,
  input  logic             ex_BrEn,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       PCSel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       state_o,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MC_WAIT  = 2'b10,
    UNUSED   = 2'b11
  } state_t;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b10;

  state_t state, next_state;
  logic   mc_pend, mc_pend_next;
  logic   mem_wait, ctrl_xfer, load_use, mc_ctx, mc_stall, redirect;

  assign mem_wait  = mem_req && !mem_ready;
  assign ctrl_xfer = ex_BrEn || (ex_opcode == `JAL) || (ex_opcode == `JALR);
  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // A memory wait that interrupted a MUL/DIV resumes the multi-cycle wait once MEM completes.
  assign mc_ctx   = (state == MC_WAIT) || ((state == MEM_WAIT) && mc_pend);
  assign mc_stall = mc_ctx ? !mc_done : (ex_mc_start && !mc_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      mc_pend <= 1'b0;
    end else begin
      state   <= next_state;
      mc_pend <= mc_pend_next;
    end
  end

  always_comb begin
    next_state   = RUN;
    mc_pend_next = 1'b0;
    redirect     = 1'b0;
    PCSel        = PC_SEQ;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    if (mem_wait) begin
      PCSel        = PC_HOLD;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_flush  = 1'b1;
      next_state   = MEM_WAIT;
      mc_pend_next = mc_ctx || (ex_mc_start && !mc_done);
    end else if (mc_stall) begin
      PCSel       = PC_HOLD;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
      next_state  = MC_WAIT;
    end else if (ctrl_xfer) begin
      PCSel      = PC_TGT;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      redirect   = 1'b1;
    end else if (load_use) begin
      PCSel      = PC_HOLD;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
    if (!rst) begin
      redirect    = 1'b0;
      PCSel       = PC_HOLD;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  assign state_o = state;

  generate
    if (MC_MAX_CYC > 0) begin : g_wdog
      localparam int WD_W = $clog2(MC_MAX_CYC + 1);
      logic [WD_W-1:0] mc_cnt;
      // mc_cnt holds the number of MC_WAIT cycles spent so far, including the current one.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mc_cnt     <= '0;
          mc_timeout <= 1'b0;
        end else if (next_state == MC_WAIT) begin
          if (mc_cnt != WD_W'(MC_MAX_CYC)) mc_cnt <= mc_cnt + WD_W'(1);
          if (mc_cnt >= WD_W'(MC_MAX_CYC - 1)) mc_timeout <= 1'b1;
        end else begin
          mc_cnt <= '0;
        end
      end
    end else begin : g_no_wdog
      assign mc_timeout = 1'b0;
    end
  endgenerate

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect)  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
  // {PCSel, pc/ifid/idex/exmem_write, ifid/idex/exmem/memwb_flush}
  localparam logic [9:0] C_NONE  = 10'b00_1111_0000;
  localparam logic [9:0] C_RST   = 10'b10_0000_1111;
  localparam logic [9:0] C_MEMW  = 10'b10_0000_0001;
  localparam logic [9:0] C_MC    = 10'b10_0001_0010;
  localparam logic [9:0] C_REDIR = 10'b01_1111_1100;
  localparam logic [9:0] C_LU    = 10'b10_0011_0100;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_BrEn, ex_mc_start, mc_done, mem_req, mem_ready;
  logic [6:0] ex_opcode;
  logic [1:0] PCSel, state_o;
  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, mc_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [9:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;
  int st_exp   = 0;
  int fl_exp   = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MC_MAX_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_opcode(ex_opcode), .ex_BrEn(ex_BrEn),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .PCSel(PCSel), .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .state_o(state_o),
    .mc_timeout(mc_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {PCSel, pc_write, ifid_write, idex_write, exmem_write,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_opcode = 7'd0; ex_BrEn = 1'b0;
    ex_mc_start = 1'b0; mc_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
`ifdef HAZ_PERF_CNT_EN
    return 64'(n);
`else
    return 64'd0;
`endif
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    #3;
    check("rst_ctl", ctl, C_RST);
    check("rst_state", state_o, 2'b00);
    check("rst_tmo", mc_timeout, 1'b0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    #4 rst = 1'b1;
    step();
    #1 check("run_idle", ctl, C_NONE);

    // load x5 in EX, add x6,x5,x1 in ID
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    #1 check("lu_rs1", ctl, C_LU);
    st_exp++;
    step();
    ex_memread = 1'b0; ex_rd = 5'd0;
    #1 check("lu_release", ctl, C_NONE);
    check("lu_release_state", state_o, 2'b00);
    ex_memread = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b0; id_rs2 = 5'd5;
    #1 check("lu_rs2", ctl, C_LU);
    st_exp++;
    step();
    id_use_rs2 = 1'b0;
    #1 check("lu_rs2_unused", ctl, C_NONE);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1 check("lu_x0", ctl, C_NONE);

    ex_rd = 5'd5; id_rs1 = 5'd5; ex_BrEn = 1'b1;
    #1 check("br_over_lu", ctl, C_REDIR);
    fl_exp++;
    step();
    idle();
    ex_opcode = 7'b1100111;
    #1 check("jalr", ctl, C_REDIR);
    fl_exp++;
    step();
    ex_opcode = 7'b1100011;
    #1 check("br_not_taken", ctl, C_NONE);
    ex_opcode = 7'b1101111;
    #1 check("jal", ctl, C_REDIR);
    fl_exp++;
    step();
    idle();
    #1 check("cnt_stall_a", stall_cnt, cnt_exp(st_exp));
    check("cnt_flush_a", flush_cnt, cnt_exp(fl_exp));

    // MUL/DIV done five cycles after start
    ex_mc_start = 1'b1;
    #1 check("mc_start_ctl", ctl, C_MC);
    check("mc_start_state", state_o, 2'b00);
    st_exp++;
    step();
    ex_mc_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 check("mc_wait_state", state_o, 2'b10);
      check("mc_wait_ctl", ctl, C_MC);
      check("mc_wait_tmo", mc_timeout, (i >= 4) ? 1'b1 : 1'b0);
      st_exp++;
      step();
    end
    mc_done = 1'b1;
    #1 check("mc_done_state", state_o, 2'b10);
    check("mc_done_ctl", ctl, C_NONE);
    step();
    mc_done = 1'b0;
    #1 check("mc_back_run", state_o, 2'b00);
    check("mc_tmo_sticky", mc_timeout, 1'b1);

    ex_mc_start = 1'b1; mc_done = 1'b1;
    #1 check("mc_single_ctl", ctl, C_NONE);
    step();
    idle();
    #1 check("mc_single_state", state_o, 2'b00);

    // memory wait with a taken branch sitting in EX
    mem_req = 1'b1; ex_BrEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("memw_ctl", ctl, C_MEMW);
      check("memw_state", state_o, (i == 0) ? 2'b00 : 2'b01);
      st_exp++;
      step();
    end
    mem_ready = 1'b1;
    #1 check("memw_ready_state", state_o, 2'b01);
    check("memw_ready_redir", ctl, C_REDIR);
    fl_exp++;
    step();
    idle();
    #1 check("memw_back_run", state_o, 2'b00);

    // memory wait interrupting a MUL/DIV wait
    ex_mc_start = 1'b1;
    #1 check("mcm_start", ctl, C_MC);
    st_exp++;
    step();
    ex_mc_start = 1'b0; mem_req = 1'b1;
    #1 check("mcm_state_mc", state_o, 2'b10);
    check("mcm_memw1", ctl, C_MEMW);
    st_exp++;
    step();
    #1 check("mcm_state_mem", state_o, 2'b01);
    check("mcm_memw2", ctl, C_MEMW);
    st_exp++;
    step();
    mem_ready = 1'b1;
    #1 check("mcm_ready_ctl", ctl, C_MC);
    st_exp++;
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1 check("mcm_resume_state", state_o, 2'b10);
    mc_done = 1'b1;
    #1 check("mcm_done_ctl", ctl, C_NONE);
    step();
    mc_done = 1'b0;
    #1 check("mcm_back_run", state_o, 2'b00);
    check("cnt_stall_b", stall_cnt, cnt_exp(st_exp));
    check("cnt_flush_b", flush_cnt, cnt_exp(fl_exp));

    #1 rst = 1'b0;
    #1 check("rst2_tmo", mc_timeout, 1'b0);
    check("rst2_stall_cnt", stall_cnt, 0);
    check("rst2_flush_cnt", flush_cnt, 0);
    rst = 1'b1;
    step();

    // watchdog: mc_done held low, then asynchronous reset mid-wait
    ex_mc_start = 1'b1;
    #1 check("wd_start", ctl, C_MC);
    step();
    ex_mc_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1 check("wd_state", state_o, 2'b10);
      check("wd_tmo", mc_timeout, (i >= 4) ? 1'b1 : 1'b0);
      if (i < 6) step();
    end
    #1 rst = 1'b0;
    #1 check("wd_rst_state", state_o, 2'b00);
    check("wd_rst_tmo", mc_timeout, 1'b0);
    check("wd_rst_ctl", ctl, C_RST);
    check("wd_rst_stall_cnt", stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
